// File: rtl/timer_a_counter.sv
// Timer_A main counter: TAxR, ID/IDEX input divider, MC count modes and TAIFG flag.
// Define TIMERA_IDEX_EN to include the IDEX extended divider stage (divide up to 64).
module timer_a_counter #(
    parameter int unsigned TAR_WIDTH = 16,
    parameter int unsigned PRE_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic [1:0]           MC,
    input  logic [1:0]           ID,
    input  logic [2:0]           IDEX,
    input  logic                 TACLR,
    input  logic                 TARwr,
    input  logic [TAR_WIDTH-1:0] TARdin,
    input  logic [TAR_WIDTH-1:0] TAxCCR0,
    input  logic                 TAIFGset_sw,
    input  logic                 TAIFGclr_sw,
    input  logic                 TAIFGclr,
    output logic [TAR_WIDTH-1:0] TAR,
    output logic                 wTAIFG,
    output logic                 count_tick,
    output logic                 dir_down,
    output logic                 equ0
);

    typedef enum logic [1:0] {ModeStop, ModeUp, ModeCont, ModeUpDown} mode_e;

    localparam logic [TAR_WIDTH-1:0] TarOne = TAR_WIDTH'(1);

`ifdef TIMERA_IDEX_EN
    localparam int unsigned PreW = PRE_WIDTH;
    logic [2:0] idex_eff;
    assign idex_eff = IDEX;
`else
    localparam int unsigned PreW = 3;
    logic [2:0] idex_eff;
    logic       unused_idex;
    assign idex_eff    = 3'd0;
    assign unused_idex = ^IDEX;
`endif

    mode_e                mode;
    logic [PreW:0]        div_full;
    logic [PreW-1:0]      pre_term;
    logic [PreW-1:0]      pre_q, pre_d;
    logic [TAR_WIDTH-1:0] tar_q, tar_d, tar_cnt;
    logic                 dir_q, dir_d, dir_cnt;
    logic                 ifg_q, ifg_d;
    logic                 tick_q, tick_d;
    logic                 pre_hit, dtick, cnt_ifg;

    assign mode     = mode_e'(MC);
    assign div_full = (PreW + 1)'({1'b0, idex_eff} + 4'd1) << ID;
    assign pre_term = PreW'(div_full - 1'b1);
    // >= so that shrinking the divide on the fly wraps on the very next tick
    assign pre_hit  = pre_q >= pre_term;
    assign dtick    = (mode != ModeStop) && tick_in && !TACLR && !TARwr && pre_hit;

    // Count-mode successor of TAR; only applied when dtick fires.
    always_comb begin
        tar_cnt = tar_q;
        dir_cnt = dir_q;
        cnt_ifg = 1'b0;
        case (mode)
            ModeUp: begin
                dir_cnt = 1'b0;
                if (TAxCCR0 == '0) begin
                    tar_cnt = '0;
                end else if (tar_q == TAxCCR0) begin
                    tar_cnt = '0;
                    cnt_ifg = 1'b1;
                end else if (tar_q > TAxCCR0) begin
                    tar_cnt = '0;
                end else begin
                    tar_cnt = tar_q + 1'b1;
                end
            end
            ModeCont: begin
                dir_cnt = 1'b0;
                tar_cnt = tar_q + 1'b1;
                cnt_ifg = &tar_q;
            end
            ModeUpDown: begin
                if (TAxCCR0 == '0) begin
                    tar_cnt = '0;
                    dir_cnt = 1'b0;
                end else if (!dir_q) begin
                    if (tar_q >= TAxCCR0) begin
                        tar_cnt = tar_q - 1'b1;
                        dir_cnt = 1'b1;
                    end else begin
                        tar_cnt = tar_q + 1'b1;
                    end
                end else if (tar_q <= TarOne) begin
                    tar_cnt = '0;
                    dir_cnt = 1'b0;
                    cnt_ifg = 1'b1;
                end else begin
                    tar_cnt = tar_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        tar_d = tar_q;
        pre_d = pre_q;
        dir_d = dir_q;
        if (TACLR) begin
            tar_d = '0;
            pre_d = '0;
            dir_d = 1'b0;
        end else begin
            // Stop holds direction; only up/continuous force counting up
            if (mode == ModeUp || mode == ModeCont) begin
                dir_d = 1'b0;
            end
            if (TARwr) begin
                tar_d = TARdin;
                pre_d = '0;
            end else if (mode != ModeStop && tick_in) begin
                pre_d = pre_hit ? '0 : pre_q + 1'b1;
                if (pre_hit) begin
                    tar_d = tar_cnt;
                    dir_d = dir_cnt;
                end
            end
        end
    end

    always_comb begin
        tick_d = dtick && (tar_cnt != tar_q);
        if ((dtick && cnt_ifg) || TAIFGset_sw) begin
            ifg_d = 1'b1;
        end else if (TAIFGclr || TAIFGclr_sw) begin
            ifg_d = 1'b0;
        end else begin
            ifg_d = ifg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tar_q  <= '0;
            pre_q  <= '0;
            dir_q  <= 1'b0;
            ifg_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tar_q  <= tar_d;
            pre_q  <= pre_d;
            dir_q  <= dir_d;
            ifg_q  <= ifg_d;
            tick_q <= tick_d;
        end
    end

    assign TAR        = tar_q;
    assign wTAIFG     = ifg_q;
    assign count_tick = tick_q;
    assign dir_down   = dir_q;
    assign equ0       = (tar_q == TAxCCR0);

endmodule

// File: tb/tb_timer_a_counter.sv
// Self-checking bench for timer_a_counter: directed test-plan sequences plus random stimulus,
// all checked by a scoreboard fed from a behavioural model of the counter rules.
module tb_timer_a_counter;

`ifdef TIMERA_IDEX_EN
    localparam bit IdexEn = 1'b1;
`else
    localparam bit IdexEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_in;
    logic [1:0]  MC;
    logic [1:0]  ID;
    logic [2:0]  IDEX;
    logic        TACLR;
    logic        TARwr;
    logic [15:0] TARdin;
    logic [15:0] TAxCCR0;
    logic        TAIFGset_sw;
    logic        TAIFGclr_sw;
    logic        TAIFGclr;
    logic [15:0] TAR;
    logic        wTAIFG;
    logic        count_tick;
    logic        dir_down;
    logic        equ0;

    timer_a_counter #(.TAR_WIDTH(16), .PRE_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .MC         (MC),
        .ID         (ID),
        .IDEX       (IDEX),
        .TACLR      (TACLR),
        .TARwr      (TARwr),
        .TARdin     (TARdin),
        .TAxCCR0    (TAxCCR0),
        .TAIFGset_sw(TAIFGset_sw),
        .TAIFGclr_sw(TAIFGclr_sw),
        .TAIFGclr   (TAIFGclr),
        .TAR        (TAR),
        .wTAIFG     (wTAIFG),
        .count_tick (count_tick),
        .dir_down   (dir_down),
        .equ0       (equ0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] tar;
        logic        ifg;
        logic        ct;
        logic        dir;
        logic        eq;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_next;
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cycle = 0;

    // Model state
    int m_tar, m_pre, m_dir, m_ifg;

    task automatic model_reset();
        m_tar = 0;
        m_pre = 0;
        m_dir = 0;
        m_ifg = 0;
    endtask

    // One clock of the timer rules, from current inputs; result goes to exp_next.
    task automatic model_clk();
        int div, ntar, ndir, ccr;
        bit dt, evt, ct;
        ccr  = int'(TAxCCR0);
        div  = (1 << ID) * (IdexEn ? (int'(IDEX) + 1) : 1);
        ntar = m_tar;
        ndir = m_dir;
        dt   = 1'b0;
        evt  = 1'b0;
        if (TACLR) begin
            ntar  = 0;
            m_pre = 0;
            ndir  = 0;
        end else if (TARwr) begin
            ntar  = int'(TARdin);
            m_pre = 0;
        end else if (MC != 2'd0 && tick_in) begin
            if (m_pre + 1 >= div) begin
                m_pre = 0;
                dt    = 1'b1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (dt) begin
            case (MC)
                2'd1: begin
                    if (ccr == 0) ntar = 0;
                    else if (m_tar == ccr) begin ntar = 0; evt = 1'b1; end
                    else if (m_tar > ccr) ntar = 0;
                    else ntar = m_tar + 1;
                end
                2'd2: begin
                    ntar = (m_tar + 1) % 65536;
                    evt  = (m_tar == 65535);
                end
                2'd3: begin
                    if (ccr == 0) begin ntar = 0; ndir = 0; end
                    else if (m_dir == 0) begin
                        if (m_tar >= ccr) begin ntar = m_tar - 1; ndir = 1; end
                        else ntar = m_tar + 1;
                    end else if (m_tar <= 1) begin
                        ntar = 0; ndir = 0; evt = 1'b1;
                    end else ntar = m_tar - 1;
                end
                default: ;
            endcase
        end
        if (!TACLR && (MC == 2'd1 || MC == 2'd2)) ndir = 0;
        ct = dt && (ntar != m_tar);
        if (evt || TAIFGset_sw) m_ifg = 1;
        else if (TAIFGclr || TAIFGclr_sw) m_ifg = 0;
        m_tar        = ntar;
        m_dir        = ndir;
        exp_next.tar = 16'(m_tar);
        exp_next.ifg = (m_ifg != 0);
        exp_next.ct  = ct;
        exp_next.dir = (m_dir != 0);
        exp_next.eq  = (m_tar == ccr);
    endtask

    // Monitor: compare the DUT against the oldest expectation once per clock.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            n_tests = n_tests + 1;
            if ({TAR, wTAIFG, count_tick, dir_down, equ0} !== mon_e) begin
                n_fail = n_fail + 1;
                $display("FAIL scoreboard cycle %0d: got tar=%h ifg=%b ct=%b dir=%b eq=%b, expected tar=%h ifg=%b ct=%b dir=%b eq=%b",
                         n_cycle, TAR, wTAIFG, count_tick, dir_down, equ0,
                         mon_e.tar, mon_e.ifg, mon_e.ct, mon_e.dir, mon_e.eq);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        model_clk();
        @(posedge clk);
        sb_q.push_back(exp_next);
        n_cycle = n_cycle + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic strobes_off();
        TACLR       = 1'b0;
        TARwr       = 1'b0;
        TAIFGset_sw = 1'b0;
        TAIFGclr_sw = 1'b0;
        TAIFGclr    = 1'b0;
    endtask

    int cyc;
    int div_exp;

    initial begin
        rst_n   = 1'b0;
        tick_in = 1'b0;
        MC      = 2'd0;
        ID      = 2'd0;
        IDEX    = 3'd0;
        TARdin  = 16'd0;
        TAxCCR0 = 16'd0;
        strobes_off();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_tar", int'(TAR), 0);
        check("reset_ifg", int'(wTAIFG), 0);
        check("reset_ct", int'(count_tick), 0);
        check("reset_dir", int'(dir_down), 0);
        #1;
        rst_n = 1'b1;

        // Up mode, CCR0=3, tick every clk
        MC = 2'd1; TAxCCR0 = 16'd3; tick_in = 1'b1;
        step();
        check("up_ct_after_first", int'(count_tick), 1);
        step(); step();
        check("up_tar3", int'(TAR), 3);
        check("up_ifg_before_wrap", int'(wTAIFG), 0);
        step();
        check("up_wrap_tar", int'(TAR), 0);
        check("up_wrap_ifg", int'(wTAIFG), 1);
        repeat (4) step();
        tick_in = 1'b0; TAIFGclr = 1'b1;
        step();
        check("up_ifg_clr", int'(wTAIFG), 0);
        TAIFGclr = 1'b0;

        // Up/down mode, CCR0=2
        MC = 2'd3; TAxCCR0 = 16'd2; TACLR = 1'b1; tick_in = 1'b1;
        step();
        TACLR = 1'b0;
        step(); step(); step();
        check("ud_tar_down1", int'(TAR), 1);
        check("ud_dir_down", int'(dir_down), 1);
        check("ud_no_ifg_at_top", int'(wTAIFG), 0);
        step();
        check("ud_tar0", int'(TAR), 0);
        check("ud_ifg_at_zero", int'(wTAIFG), 1);
        check("ud_dir_up", int'(dir_down), 0);
        step();
        check("ud_tar_up1", int'(TAR), 1);
        tick_in = 1'b0; TAIFGclr = 1'b1;
        step();
        check("ud_ifg_clr", int'(wTAIFG), 0);
        TAIFGclr = 1'b0;

        // Continuous wrap with simultaneous hardware clear
        MC = 2'd2; tick_in = 1'b1; TARwr = 1'b1; TARdin = 16'hFFFE;
        step();
        TARwr = 1'b0;
        check("cont_wr", int'(TAR), 16'hFFFE);
        step();
        check("cont_ffff", int'(TAR), 16'hFFFF);
        TAIFGclr = 1'b1;
        step();
        TAIFGclr = 1'b0;
        check("cont_wrap_tar", int'(TAR), 0);
        check("cont_set_beats_clr", int'(wTAIFG), 1);

        // Divider ID=1, IDEX=2
        ID = 2'd1; IDEX = 3'd2; TACLR = 1'b1;
        step();
        TACLR   = 1'b0;
        div_exp = IdexEn ? 6 : 2;
        cyc = 0;
        while (TAR != 16'd1 && cyc < 20) begin step(); cyc++; end
        check("div_first_inc", cyc, div_exp);
        cyc = 0;
        while (TAR != 16'd2 && cyc < 20) begin step(); cyc++; end
        check("div_second_inc", cyc, div_exp);
        ID = 2'd0; IDEX = 3'd0;

        // Up mode CCR0=10, TACLR with TARwr, then CCR0=0
        MC = 2'd1; TAxCCR0 = 16'd10; TACLR = 1'b1; TAIFGset_sw = 1'b1;
        step();
        TACLR = 1'b0; TAIFGset_sw = 1'b0;
        repeat (5) step();
        check("clr_pre_tar5", int'(TAR), 5);
        TACLR = 1'b1; TARwr = 1'b1; TARdin = 16'd7;
        step();
        TACLR = 1'b0; TARwr = 1'b0;
        check("clr_beats_wr", int'(TAR), 0);
        check("clr_keeps_ifg", int'(wTAIFG), 1);
        TAxCCR0 = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ccr0_zero_tar", int'(TAR), 0);
            check("ccr0_zero_ct", int'(count_tick), 0);
        end
        TAIFGclr_sw = 1'b1;
        step();
        TAIFGclr_sw = 1'b0;

        // Random stimulus
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) MC = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) TAxCCR0 = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) begin
                ID   = 2'($urandom_range(0, 3));
                IDEX = 3'($urandom_range(0, 7));
            end
            tick_in     = ($urandom_range(0, 3) != 0);
            TACLR       = ($urandom_range(0, 59) == 0);
            TARwr       = ($urandom_range(0, 39) == 0);
            TARdin      = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20))
                                                      : 16'($urandom_range(16'hFFF0, 16'hFFFF));
            TAIFGset_sw = ($urandom_range(0, 29) == 0);
            TAIFGclr_sw = ($urandom_range(0, 29) == 0);
            TAIFGclr    = ($urandom_range(0, 19) == 0);
            step();
        end
        strobes_off();

        // Asynchronous reset while counting down in up/down mode
        MC = 2'd3; TAxCCR0 = 16'd3; ID = 2'd0; IDEX = 3'd0; tick_in = 1'b1;
        TACLR = 1'b1; TAIFGset_sw = 1'b1;
        step();
        TACLR = 1'b0; TAIFGset_sw = 1'b0;
        repeat (4) step();
        check("pre_rst_dir", int'(dir_down), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tar", int'(TAR), 0);
        check("async_rst_ifg", int'(wTAIFG), 0);
        check("async_rst_dir", int'(dir_down), 0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_a_counter.md
Name: timer_a_counter

Overview:
Timer_A main counter stage. It holds TAxR, applies the ID/IDEX input divider and implements the four MC count modes. It produces the TAIFG flag level and the count strobe that feed the Timer_A interrupt/vector block and the capture/compare channels. TAIFG is cleared by the interrupt block's TAIFGclr output or by a software write.

Parameters:
TAR_WIDTH, 16, width of TAxR and TAxCCR0 compare.
PRE_WIDTH, 6, width of prescaler counter; max total divide is 64.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
tick_in  input  1  one-clk timer-clock enable from clock-source select; counting only advances on these.
MC  input  2  mode: 0 stop, 1 up, 2 continuous, 3 up/down.
ID  input  2  divider, divide by 2^ID.
IDEX  input  3  extended divider, divide by IDEX+1.
TACLR  input  1  one-clk clear strobe.
TARwr  input  1  software write strobe to TAxR.
TARdin  input  TAR_WIDTH  write data for TAxR.
TAxCCR0  input  TAR_WIDTH  CCR0 compare value.
TAIFGset_sw  input  1  software write of 1 to TAIFG.
TAIFGclr_sw  input  1  software write of 0 to TAIFG.
TAIFGclr  input  1  hardware clear from interrupt/vector block (IV read).
TAR  output  TAR_WIDTH  current counter value.
wTAIFG  output  1  TAIFG flag level to interrupt block.
count_tick  output  1  registered one-clk strobe: TAR changed by counting this cycle.
dir_down  output  1  1 while up/down mode is counting down.
equ0  output  1  combinational TAR == TAxCCR0.

Behaviour:
- Reset (rst_n low, asynchronous): TAR=0, prescaler=0, wTAIFG=0, count_tick=0, dir_down=0.
- Divider: the prescaler counts tick_in pulses while MC!=0. A divided tick (dtick) fires on the tick_in where prescaler == 2^ID*(IDEX+1)-1; the prescaler then returns to 0.
  - Divide 1 gives dtick on every tick_in.
  - Changing ID/IDEX does not reset the prescaler. If the prescaler is already at or above the new terminal value, the next tick_in produces dtick and wraps.
- On each dtick, TAR updates in the same clk and count_tick=1 on the following clk.
- Stop (MC=0): TAR, prescaler and direction hold. No dtick.
- Up (MC=1):
  - TAR<CCR0: increment.
  - TAR==CCR0: go to 0 and set TAIFG.
  - TAR>CCR0: go to 0 with no TAIFG.
  - CCR0==0: TAR stays 0, no TAIFG, no count_tick.
- Continuous (MC=2): increment. FFFF->0 wraps and sets TAIFG.
- Up/down (MC=3):
  - Counting up: when TAR==CCR0, set dir_down=1 and decrement. At TAR>CCR0, same action.
  - Counting down: when TAR reaches 1, the next dtick goes to 0, sets TAIFG and sets dir_down=0. The next dtick after that counts up to 1.
  - CCR0==0: hold at 0, no TAIFG.
- Leaving mode 3: dir_down is cleared and counting proceeds up.
- Priority in one clk: TACLR > TARwr > counting.
  - TACLR zeroes TAR, prescaler and dir_down, and suppresses any dtick/TAIFG set that cycle. TACLR does not touch TAIFG.
  - TARwr loads TARdin, resets the prescaler and suppresses that cycle's dtick.
- TAIFG:
  - Set by a count event or TAIFGset_sw.
  - Cleared by TAIFGclr or TAIFGclr_sw.
  - Set beats clear when both occur in the same clk.
- equ0 is purely combinational and valid in every mode.

Optional Feature:
TIMERA_IDEX_EN:
- Defined: the IDEX stage is present and the total divide is 2^ID*(IDEX+1), up to 64.
- Undefined: IDEX is ignored and treated as 0. Divide is 2^ID only (max 8), and the prescaler may be synthesized at 3 bits.
- All other behaviour is identical in both cases.

Test Plan:
- Up mode, CCR0=3, ID=0, IDEX=0, tick_in every clk:
  - Required: TAR 0,1,2,3,0,1...
  - Required: wTAIFG rises the clk TAR goes 3->0.
  - Required: count_tick on every cycle following a dtick.
- Up/down mode, CCR0=2:
  - Required: TAR 0,1,2,1,0,1; dir_down=1 during 2->1->0.
  - Required: TAIFG set only on 1->0.
  - TAIFGclr pulse: the flag drops the next clk.
- Continuous mode, TARwr TARdin=FFFE, then two tick_in:
  - Required: FFFF then 0000, TAIFG=1.
  - Hold TAIFGclr high at the same clk as the wrap: TAIFG remains 1.
- Divider ID=1, IDEX=2 (macro defined), tick_in every clk:
  - Required: TAR increments every 6 clks.
  - With the macro undefined: TAR increments every 2 clks.
- Up mode, CCR0=10, TAR counted to 5, then TACLR asserted together with TARwr:
  - Required: TAR=0 and prescaler=0, with no TAIFG change.
  - Then set CCR0=0: TAR holds 0 and count_tick stays low.
- Assert rst_n low mid-count between clk edges:
  - Required: TAR, wTAIFG and dir_down go 0 immediately, without waiting for a clk edge.
